sleep_ctrl: RTL and testbench

Power-management sequencer for the 5-stage pipeline core's sleep path. Runs on the free-running clock and sequences WFI-driven sleep entry in four steps: stall fetch, wait for the pipeline to drain, drop the clock-gate enable, and hold it low until an interrupt or debug request arrives. It then restores the clock, waits a fixed settling delay before releasing fetch, and counts cycles spent asleep. Its `clk_en_o` drives the core's clock-gate cell.

---
 rtl/sleep_pkg.sv | 16 +
 rtl/sleep_ctrl_sat_counter.sv | 21 ++
 rtl/sleep_ctrl.sv | 104 ++++++++++
 tb/tb_sleep_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/sleep_pkg.sv
// sleep_pkg: shared state encoding and counter-width helper for the sleep sequencer.
package sleep_pkg;

   typedef enum logic [2:0] {
      RUN,
      DRAIN,
      GATE,
      SLEEP,
      WAKE
   } sleep_state_e;

   function automatic int cnt_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sleep_ctrl_sat_counter.sv
// sat_counter: clearable up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en && !(&cnt))
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/sleep_ctrl.sv
// sleep_ctrl: WFI sleep sequencer driving the core clock-gate enable.
// All outputs are registered from next-state decode so clk_en_o is glitch-free.
module sleep_ctrl
   import sleep_pkg::*;
#(
   parameter int DRAIN_TIMEOUT = 64,
   parameter int WAKE_DELAY    = 4,
   parameter int CNT_W         = 32
) (
   input  logic             clk_i,
   input  logic             rst_n,
   input  logic             wfi_req_i,
   input  logic             pipe_empty_i,
   input  logic             irq_pending_i,
   input  logic             dbg_req_i,
   output logic             stall_fetch_o,
   output logic             clk_en_o,
   output logic             core_sleep_o,
   output logic             wake_o,
   output logic             drain_err_o,
   output logic [CNT_W-1:0] sleep_cnt_o
);

   localparam int DW = cnt_w(DRAIN_TIMEOUT);
   localparam int WW = cnt_w(WAKE_DELAY);

   sleep_state_e  state, next;
   logic [DW-1:0] drain_cnt, drain_nxt;
   logic [WW-1:0] wake_cnt, wake_nxt;
   logic          wake_src, timeout, err_nxt, gated_nxt;

   assign wake_src  = irq_pending_i | dbg_req_i;
   assign timeout   = drain_cnt == DW'(DRAIN_TIMEOUT - 1);
   assign gated_nxt = (next == GATE) || (next == SLEEP);

   always_comb begin
      next      = state;
      drain_nxt = drain_cnt;
      wake_nxt  = wake_cnt;
      err_nxt   = 1'b0;
      case (state)
         RUN:
            if (wfi_req_i && !wake_src) begin
               next      = DRAIN;
               drain_nxt = '0;
            end
         DRAIN:
            // abort beats a simultaneous pipe_empty so no wake pulse is owed
            if (wake_src)
               next = RUN;
            else if (pipe_empty_i)
               next = GATE;
            else if (timeout) begin
               next    = RUN;
               err_nxt = 1'b1;
            end else
               drain_nxt = drain_cnt + 1'b1;
         GATE, SLEEP:
            if (wake_src) begin
               next     = WAKE;
               wake_nxt = WW'(WAKE_DELAY - 1);
            end else
               next = SLEEP;
         WAKE:
            if (wake_cnt == '0)
               next = RUN;
            else
               wake_nxt = wake_cnt - 1'b1;
         default:
            next = RUN;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state         <= RUN;
         drain_cnt     <= '0;
         wake_cnt      <= '0;
         stall_fetch_o <= 1'b0;
         clk_en_o      <= 1'b1;
         core_sleep_o  <= 1'b0;
         wake_o        <= 1'b0;
         drain_err_o   <= 1'b0;
      end else begin
         state         <= next;
         drain_cnt     <= drain_nxt;
         wake_cnt      <= wake_nxt;
         stall_fetch_o <= next != RUN;
         clk_en_o      <= !gated_nxt;
         core_sleep_o  <= gated_nxt;
         wake_o        <= (state == WAKE) && (next == RUN);
         drain_err_o   <= err_nxt;
      end
   end

   sat_counter #(.W(CNT_W)) u_sleep_cnt (
      .clk   (clk_i),
      .rst_n (rst_n),
      .clr   ((state == DRAIN) && (next == GATE)),
      .en    (state == SLEEP),
      .cnt   (sleep_cnt_o)
   );

endmodule

// File: tb/tb_sleep_ctrl.sv
// tb_sleep_ctrl: directed per-cycle vectors pushed to a scoreboard, checked by a
// separate monitor on the falling edge (or on demand for the async-reset check).
module tb_sleep_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wfi = 1'b0, pe = 1'b0, irq = 1'b0, dbg = 1'b0;
   logic       stall, clk_en, core_sleep, wake, derr;
   logic [3:0] cnt;

   typedef struct {
      logic [8:0] v;
      string      n;
   } exp_t;

   exp_t q[$];
   exp_t e;
   event chk_now;
   int   tests = 0, fails = 0;
   logic [8:0] act;

   // {clk_en, stall, core_sleep, wake, drain_err}
   localparam logic [4:0] O_RUN = 5'b10000;
   localparam logic [4:0] O_STL = 5'b11000;
   localparam logic [4:0] O_SLP = 5'b01100;
   localparam logic [4:0] O_WK  = 5'b10010;
   localparam logic [4:0] O_ER  = 5'b10001;

   always #5 clk = ~clk;

   sleep_ctrl #(.DRAIN_TIMEOUT(8), .WAKE_DELAY(4), .CNT_W(4)) dut (
      .clk_i         (clk),
      .rst_n         (rst_n),
      .wfi_req_i     (wfi),
      .pipe_empty_i  (pe),
      .irq_pending_i (irq),
      .dbg_req_i     (dbg),
      .stall_fetch_o (stall),
      .clk_en_o      (clk_en),
      .core_sleep_o  (core_sleep),
      .wake_o        (wake),
      .drain_err_o   (derr),
      .sleep_cnt_o   (cnt)
   );

   initial forever begin
      @(negedge clk or chk_now);
      while (q.size() > 0) begin
         e = q.pop_front();
         act = {clk_en, stall, core_sleep, wake, derr, cnt};
         tests++;
         if (act !== e.v) begin
            fails++;
            $display("FAIL %s: got en/st/sl/wk/er=%b cnt=%0d, want en/st/sl/wk/er=%b cnt=%0d",
                     e.n, act[8:4], act[3:0], e.v[8:4], e.v[3:0]);
         end
      end
   end

   task automatic tick(input logic [4:0] o, input int c, input string n);
      exp_t x;
      @(posedge clk);
      x.v = {o, 4'(c)};
      x.n = n;
      q.push_back(x);
      @(negedge clk);
   endtask

   task automatic push_now(input logic [4:0] o, input int c, input string n);
      exp_t x;
      x.v = {o, 4'(c)};
      x.n = n;
      q.push_back(x);
      ->chk_now;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (2) @(negedge clk);
      #1 push_now(O_RUN, 0, "reset_values");
      #1 rst_n = 1'b1;
      @(negedge clk);
      // full sleep cycle woken by irq after 10 SLEEP cycles
      wfi = 1'b1; pe = 1'b1;
      tick(O_STL, 0, "entry_stall");
      wfi = 1'b0;
      tick(O_SLP, 0, "entry_gate");
      tick(O_SLP, 0, "gate_to_sleep");
      for (int i = 1; i <= 9; i++) tick(O_SLP, i, "sleep_count");
      irq = 1'b1;
      tick(O_STL, 10, "wake_clk_restored");
      irq = 1'b0;
      for (int i = 0; i < 3; i++) tick(O_STL, 10, "wake_delay");
      tick(O_WK, 10, "wake_pulse");
      tick(O_RUN, 10, "run_cnt_hold");
      // WFI with an interrupt already pending is a NOP
      wfi = 1'b1; irq = 1'b1;
      for (int i = 0; i < 3; i++) tick(O_RUN, 10, "wfi_nop");
      wfi = 1'b0; irq = 1'b0;
      tick(O_RUN, 10, "wfi_nop_after");
      // drain timeout
      wfi = 1'b1; pe = 1'b0;
      tick(O_STL, 10, "drain_enter");
      wfi = 1'b0;
      for (int i = 0; i < 7; i++) tick(O_STL, 10, "drain_wait");
      tick(O_ER, 10, "drain_err_pulse");
      tick(O_RUN, 10, "drain_err_release");
      // drain abort: debug request and pipe_empty together
      wfi = 1'b1;
      tick(O_STL, 10, "abort_enter");
      wfi = 1'b0; dbg = 1'b1; pe = 1'b1;
      tick(O_RUN, 10, "abort_wins");
      dbg = 1'b0; pe = 1'b0;
      tick(O_RUN, 10, "abort_after");
      // debug request already present during GATE
      wfi = 1'b1; pe = 1'b1;
      tick(O_STL, 10, "dbg_entry");
      wfi = 1'b0;
      tick(O_SLP, 0, "dbg_gate");
      dbg = 1'b1;
      tick(O_STL, 0, "gate_to_wake");
      dbg = 1'b0;
      for (int i = 0; i < 3; i++) tick(O_STL, 0, "dbg_wake_delay");
      tick(O_WK, 0, "dbg_wake_pulse");
      tick(O_RUN, 0, "dbg_run");
      // saturation over 20 SLEEP cycles, then async reset mid-sleep
      wfi = 1'b1; pe = 1'b1;
      tick(O_STL, 0, "sat_entry");
      wfi = 1'b0;
      tick(O_SLP, 0, "sat_gate");
      tick(O_SLP, 0, "sat_sleep");
      for (int i = 1; i <= 20; i++) tick(O_SLP, (i > 15) ? 15 : i, "sat_count");
      pe = 1'b0;
      #2 rst_n = 1'b0;
      #1 push_now(O_RUN, 0, "async_reset");
      #1 rst_n = 1'b1;
      tick(O_RUN, 0, "post_reset_run");
      repeat (2) @(negedge clk);
      tests++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
